// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bus of the fetch/load-store memory arbiter.
// The arbiter takes the slave view; the requesters and memory together take the master view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_valid;
    logic        ls_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_valid,
        output ls_rdata, ls_valid, ls_err,
        output mem_addr, mem_wdata, mem_wstrb, mem_rd_en, mem_wr_en
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_valid,
        input  ls_rdata, ls_valid, ls_err,
        input  mem_addr, mem_wdata, mem_wstrb, mem_rd_en, mem_wr_en
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with
// starvation protection for fetch, byte-lane handling and a ready timeout.
module mem_arbiter_chk (
    input logic       clk,
    input logic       rst,
    input logic       rd_en,
    input logic       wr_en,
    input logic       if_valid,
    input logic       ls_valid,
    input logic       ls_err,
    input logic [1:0] addr_lo
);
    a_one_strobe: assert property (@(posedge clk) disable iff (rst) !(rd_en && wr_en));
    a_one_pulse:  assert property (@(posedge clk) disable iff (rst) $onehot0({if_valid, ls_valid, ls_err}));
    a_word_addr:  assert property (@(posedge clk) disable iff (rst) addr_lo == 2'b00);
endmodule

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    function automatic logic ls_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << lane;
            2'b01:   strb = 4'b0011 << lane;
            2'b10:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {lane, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_t      state_r,     state_s;
    logic [3:0]  starve_r,    starve_s;
    logic [7:0]  wait_r,      wait_s;
    logic [1:0]  lane_r,      lane_s;
    logic [1:0]  size_r,      size_s;
    logic        uns_r,       uns_s;
    logic [31:0] mem_addr_r,  mem_addr_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;
    logic [3:0]  mem_wstrb_r, mem_wstrb_s;
    logic        mem_rd_en_r, mem_rd_en_s;
    logic        mem_wr_en_r, mem_wr_en_s;
    logic [31:0] if_rdata_r,  if_rdata_s;
    logic        if_valid_r,  if_valid_s;
    logic [31:0] ls_rdata_r,  ls_rdata_s;
    logic        ls_valid_r,  ls_valid_s;
    logic        ls_err_r,    ls_err_s;
    logic        grant_fetch_s;
    logic        pulse_busy_s;

    // Fetch addresses are word aligned, so their low bits are dropped on purpose.
    logic unused_s;
    assign unused_s = ^bus.if_addr[1:0];

    // Next-state, arbitration and output-register computation.
    always_comb begin
        state_s       = state_r;
        starve_s      = starve_r;
        wait_s        = wait_r;
        lane_s        = lane_r;
        size_s        = size_r;
        uns_s         = uns_r;
        mem_addr_s    = mem_addr_r;
        mem_wdata_s   = mem_wdata_r;
        mem_wstrb_s   = mem_wstrb_r;
        mem_rd_en_s   = mem_rd_en_r;
        mem_wr_en_s   = mem_wr_en_r;
        if_rdata_s    = if_rdata_r;
        ls_rdata_s    = ls_rdata_r;
        if_valid_s    = 1'b0;
        ls_valid_s    = 1'b0;
        ls_err_s      = 1'b0;
        grant_fetch_s = 1'b0;
        // A requester still sees its completion pulse this cycle and has not dropped its request yet.
        pulse_busy_s  = if_valid_r | ls_valid_r | ls_err_r;

        case (state_r)
            IDLE: begin
                if (!pulse_busy_s && (bus.if_req || bus.ls_req)) begin
                    grant_fetch_s = bus.if_req && (!bus.ls_req || (starve_r == STARVE_MAX));
                    wait_s        = 8'd0;
                    if (grant_fetch_s) begin
                        starve_s    = 4'd0;
                        mem_addr_s  = {bus.if_addr[31:2], 2'b00};
                        mem_wstrb_s = 4'b0000;
                        mem_rd_en_s = 1'b1;
                        state_s     = FETCH;
                    end else begin
                        if (bus.if_req && (starve_r != STARVE_MAX)) begin
                            starve_s = starve_r + 4'd1;
                        end else begin
                            starve_s = starve_r;
                        end
                        lane_s = bus.ls_addr[1:0];
                        size_s = bus.ls_size;
                        uns_s  = bus.ls_unsigned;
                        if (ls_misaligned(bus.ls_size, bus.ls_addr[1:0])) begin
                            ls_err_s = 1'b1;
                        end else if (bus.ls_we) begin
                            mem_addr_s  = {bus.ls_addr[31:2], 2'b00};
                            mem_wstrb_s = store_strobe(bus.ls_size, bus.ls_addr[1:0]);
                            mem_wdata_s = bus.ls_wdata << {bus.ls_addr[1:0], 3'b000};
                            mem_wr_en_s = 1'b1;
                            state_s     = STORE;
                        end else begin
                            mem_addr_s  = {bus.ls_addr[31:2], 2'b00};
                            mem_wstrb_s = 4'b0000;
                            mem_rd_en_s = 1'b1;
                            state_s     = LOAD;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH, LOAD, STORE: begin
                if (bus.mem_ready) begin
                    mem_rd_en_s = 1'b0;
                    mem_wr_en_s = 1'b0;
                    wait_s      = 8'd0;
                    state_s     = IDLE;
                    case (state_r)
                        FETCH: begin
                            if_valid_s = 1'b1;
                            if_rdata_s = bus.mem_rdata;
                        end
                        LOAD: begin
                            ls_valid_s = 1'b1;
                            ls_rdata_s = load_extend(bus.mem_rdata, lane_r, size_r, uns_r);
                        end
                        default: begin
                            ls_valid_s = 1'b1;
                        end
                    endcase
                end else if (wait_r == WAIT_LAST) begin
                    // Abandoned fetches are retried from IDLE since if_req is still held.
                    mem_rd_en_s = 1'b0;
                    mem_wr_en_s = 1'b0;
                    wait_s      = 8'd0;
                    state_s     = IDLE;
                    ls_err_s    = (state_r != FETCH);
                end else begin
                    wait_s = wait_r + 8'd1;
                end
            end
            default: begin
                state_s     = IDLE;
                mem_rd_en_s = 1'b0;
                mem_wr_en_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            starve_r    <= 4'd0;
            wait_r      <= 8'd0;
            lane_r      <= 2'b00;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'b0000;
            mem_rd_en_r <= 1'b0;
            mem_wr_en_r <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            if_valid_r  <= 1'b0;
            ls_rdata_r  <= 32'h0000_0000;
            ls_valid_r  <= 1'b0;
            ls_err_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            starve_r    <= starve_s;
            wait_r      <= wait_s;
            lane_r      <= lane_s;
            size_r      <= size_s;
            uns_r       <= uns_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_wstrb_r <= mem_wstrb_s;
            mem_rd_en_r <= mem_rd_en_s;
            mem_wr_en_r <= mem_wr_en_s;
            if_rdata_r  <= if_rdata_s;
            if_valid_r  <= if_valid_s;
            ls_rdata_r  <= ls_rdata_s;
            ls_valid_r  <= ls_valid_s;
            ls_err_r    <= ls_err_s;
        end
    end

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_wstrb = mem_wstrb_r;
    assign bus.mem_rd_en = mem_rd_en_r;
    assign bus.mem_wr_en = mem_wr_en_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.if_valid  = if_valid_r;
    assign bus.ls_rdata  = ls_rdata_r;
    assign bus.ls_valid  = ls_valid_r;
    assign bus.ls_err    = ls_err_r;

    mem_arbiter_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (mem_rd_en_r),
        .wr_en    (mem_wr_en_r),
        .if_valid (if_valid_r),
        .ls_valid (ls_valid_r),
        .ls_err   (ls_err_r),
        .addr_lo  (mem_addr_r[1:0])
    );
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while a fetch waits (1..15).
REQ-002 Parameter: TIMEOUT, default 15, max cycles waiting for mem_ready before abort (1..255).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch request; held until if_valid.
REQ-006 if_addr  in  32  fetch address, word-aligned.
REQ-007 if_rdata  out  32  fetched instruction.
REQ-008 if_valid  out  1  one-cycle fetch completion pulse.
REQ-009 ls_req  in  1  load/store request; held until ls_valid or ls_err.
REQ-010 ls_we  in  1  1 = store, 0 = load.
REQ-011 ls_size  in  2  00 byte, 01 half, 10 word; 11 illegal.
REQ-012 ls_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-013 ls_addr  in  32  byte address.
REQ-014 ls_wdata  in  32  store data, right-aligned.
REQ-015 ls_rdata  out  32  extended load result.
REQ-016 ls_valid  out  1  one-cycle load/store completion pulse.
REQ-017 ls_err  out  1  one-cycle pulse: misaligned, illegal size or timeout.
REQ-018 mem_addr  out  32  word address to memory (bits [1:0] forced 0).
REQ-019 mem_wdata  out  32  lane-shifted store data.
REQ-020 mem_wstrb  out  4  byte enables for stores.
REQ-021 mem_rd_en, mem_wr_en  out  1 each  access strobes; held until mem_ready.
REQ-022 mem_rdata  in  32  read data, valid when mem_ready.
REQ-023 mem_ready  in  1  access complete this cycle.

Function
REQ-024 FSM states SHALL be IDLE, FETCH, LOAD, STORE, with one outstanding memory access at most.
REQ-025 In IDLE, requests SHALL be sampled; memory strobe and all address/data/strobe outputs are registered and assert on the next cycle.
REQ-026 If only one request is valid in IDLE, it SHALL be granted.
REQ-027 If both are valid in IDLE, ls SHALL win unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-028 starve_cnt SHALL increment on each ls grant made while if_req=1, saturate at STARVE_LIMIT, and clear on every fetch grant.
REQ-029 ls misalignment (half with addr[0]=1, word with addr[1:0]!=0, or size 11) SHALL pulse ls_err one cycle after sampling, stay IDLE, issue no memory strobe.
REQ-030 Store SHALL set mem_wstrb to 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), or 1111 (word), and shift wdata by 8*addr[1:0].
REQ-031 Loads and fetches SHALL drive mem_wstrb = 0000.
REQ-032 In FETCH/LOAD/STORE, the strobe SHALL remain high until mem_ready=1 is sampled, then drop on the next cycle and the FSM returns to IDLE.
REQ-033 The completion pulse (if_valid/ls_valid) SHALL assert the cycle after mem_ready, with data registered from mem_rdata.
REQ-034 Load data SHALL be lane-selected by addr[1:0] and sign/zero-extended to 32 bits per ls_unsigned.
REQ-035 A wait counter SHALL count strobe cycles; on reaching TIMEOUT without mem_ready, drop the strobe, return to IDLE, and pulse ls_err (LOAD/STORE) or retry fetch (FETCH).
REQ-036 Back-to-back: after a completion, a new grant SHALL be decided in IDLE, giving a minimum of 3 cycles per access (sample, strobe with ready, pulse).
REQ-037 mem_ready while no strobe is asserted SHALL be ignored.

Reset
REQ-038 rst SHALL force IDLE, starve_cnt=0, wait counter=0, all outputs 0 on the next edge, including mid-access; the in-flight access is discarded with no completion pulse.

Verification
REQ-039 Fetch only: if_addr=0x100, mem_ready in the first strobe cycle, mem_rdata=0x00500093 -> mem_rd_en for 1 cycle, mem_addr=0x100, if_valid=1 and if_rdata=0x00500093 one cycle later.
REQ-040 Signed byte load: ls_addr=0x203, size=00, unsigned=0, mem_rdata=0x80FF1234 -> ls_rdata=0xFFFFFF80; with unsigned=1 -> 0x00000080.
REQ-041 Half store: ls_addr=0x42, wdata=0x0000BEEF -> mem_addr=0x40, mem_wstrb=1100, mem_wdata=0xBEEF0000, ls_valid after ready.
REQ-042 Starvation: if_req and ls_req held high, ready=1 immediately -> 4 ls grants, then 1 fetch grant, then the pattern repeats.
REQ-043 Misaligned word load at 0x6 -> ls_err pulse, no mem_rd_en; mem_ready never asserted on a legal load -> ls_err after 15 strobe cycles.
REQ-044 rst asserted during LOAD strobe -> next cycle all outputs 0, no ls_valid, next request served normally.
